param_seq_alu: RTL and testbench
================================

Name: param_seq_alu

Overview:
- Parametrised, registered successor to the 8-bit clocked ALU: width set by WIDTH, explicit start/busy/done handshake, full status flags.
- Adds a multi-cycle unsigned shift-add multiply with a double-width result.
- Sits between the register file read ports and the writeback mux. Downstream logic captures results only on done.

Parameters:
- WIDTH, 8, operand/result word width (>=4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; operands and func are sampled on the edge where start=1 and busy=0.
- func  in  3  opcode (map below).
- reg1  in  WIDTH  operand A.
- reg2  in  WIDTH  operand B.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse; all result/flag outputs are valid and updated in the same cycle.
- alu_out  out  WIDTH  result (MUL: low word).
- alu_out_hi  out  WIDTH  MUL high word; 0 for all other ops.
- carry_out  out  1  carry / borrow-complement / shifted-out bit.
- zero  out  1  result == 0 (MUL: full 2*WIDTH product == 0).
- negative  out  1  MSB of alu_out (MUL: MSB of alu_out_hi).
- overflow  out  1  signed overflow, ADD/SUB only, else 0.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs, including busy and done, go to 0.
  - Reset mid-multiply aborts it: no done, partial product discarded.
- Opcode map (A=reg1, B=reg2, W=WIDTH):
  - 000 ADD: A+B; carry = bit W of the sum; overflow = (A[msb]==B[msb]) && (sum[msb]!=A[msb]).
  - 001 SUB: A+~B+1; carry=1 means no borrow; overflow = (A[msb]!=B[msb]) && (res[msb]!=A[msb]).
  - 010 PASS: A; carry 0.
  - 011 SHL: A<<1; carry = A[msb].
  - 100 SHR (logical): A>>1; carry = A[0].
  - 101 AND: A&B; carry 0.
  - 110 NOT: ~A; carry 0.
  - 111 MUL: unsigned A*B; {alu_out_hi, alu_out} = product; carry = (alu_out_hi != 0).
- FSM states: IDLE, MUL_RUN.
  - IDLE, start=1, func!=111: result and flags registered at that edge; done=1 for the following cycle; stay in IDLE. Latency is 1 cycle, and back-to-back starts every cycle are allowed.
  - IDLE, start=1, func==111: latch A and B, clear the accumulator and counter, set busy=1, go to MUL_RUN.
  - MUL_RUN: one shift-add iteration per cycle, exactly WIDTH iterations. On the final iteration, write the outputs, pulse done, clear busy, return to IDLE.
  - MUL latency: done is high in cycle N+WIDTH+1, where N is the start cycle. busy is high for cycles N+1..N+WIDTH.
  - A new start is accepted in the same cycle done is high (busy=0).
- start while busy=1 is ignored: no queueing, outputs unchanged, no extra done.
- Outputs hold their last values until the next done. done is never high for two consecutive cycles caused by a single start.
- Arithmetic is performed at width W+1 (2W for MUL); no truncation before flag computation.

Test Plan:
- ADD, WIDTH=8, A=FF, B=01 -> next cycle: done=1, alu_out=00, carry=1, zero=1, overflow=0, negative=0, alu_out_hi=00.
- SUB, A=80, B=01 -> alu_out=7F, carry=1, overflow=1, negative=0. Then A=00, B=01 -> FF, carry=0, negative=1, overflow=0.
- MUL, A=FF, B=FF, start at cycle 0:
  - busy=1 in cycles 1..8.
  - done=1 in cycle 9 only: alu_out_hi=FE, alu_out=01, carry=1, zero=0, negative=1.
  - MUL 00*5A -> zero=1.
- start pulsed with ADD during cycles 3 and 5 of a MUL -> ignored; exactly one done (cycle 9); the MUL result is intact.
- rst asserted at cycle 4 of a MUL -> next cycle all outputs 0, busy=0, no done. A subsequent ADD 03+04 gives alu_out=07 with 1-cycle latency.
- SHL A=81 -> 02, carry=1. SHR A=01 -> 00, carry=1, zero=1. NOT A=0F -> F0. AND F0&3C -> 30.
- Re-run the ADD and MUL cases with WIDTH=16: FFFF+0001 -> 0000, carry=1; FFFF*FFFF -> FFFE_0001, done at cycle 17.

Source files
------------

// File: rtl/param_seq_alu_if.sv
// param_seq_alu_if: start/func/operand request and registered result/flag bundle for param_seq_alu.
interface param_seq_alu_if #(parameter int WIDTH = 8);
  logic             start;
  logic [2:0]       func;
  logic [WIDTH-1:0] reg1;
  logic [WIDTH-1:0] reg2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] alu_out_hi;
  logic             carry_out;
  logic             zero;
  logic             negative;
  logic             overflow;
  modport master (
    output start, func, reg1, reg2,
    input  busy, done, alu_out, alu_out_hi, carry_out, zero, negative, overflow
  );
  modport slave (
    input  start, func, reg1, reg2,
    output busy, done, alu_out, alu_out_hi, carry_out, zero, negative, overflow
  );
endinterface

// File: rtl/param_seq_alu.sv
// param_seq_alu: registered ALU, 1-cycle ops plus WIDTH-cycle shift-add unsigned multiply.
module param_seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic rst,
  param_seq_alu_if.slave bus
);
  typedef enum logic {IDLE, MUL_RUN} state_t;
  state_t state, state_d;
  logic [2*WIDTH-1:0] acc, mcand, prod;
  logic [WIDTH-1:0] mplier, a, b, res;
  logic [WIDTH:0] sum, diff;
  logic [CNT_W-1:0] cnt;
  logic last, c, ovf, go, go_mul;
  assign bus.busy = state == MUL_RUN;
  always_comb begin
    a = bus.reg1;
    b = bus.reg2;
    sum = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    res = '0;
    c = 1'b0;
    ovf = 1'b0;
    case (bus.func)
      3'b000: begin
        res = sum[WIDTH-1:0];
        c = sum[WIDTH];
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        res = diff[WIDTH-1:0];
        c = diff[WIDTH];
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: res = a;
      3'b011: begin
        res = a << 1;
        c = a[WIDTH-1];
      end
      3'b100: begin
        res = a >> 1;
        c = a[0];
      end
      3'b101: res = a & b;
      3'b110: res = ~a;
      default: res = '0;
    endcase
    go = state == IDLE && bus.start;
    go_mul = go && bus.func == 3'b111;
    prod = acc + (mplier[0] ? mcand : '0);
    last = cnt == CNT_W'(WIDTH - 1);
    state_d = go_mul ? MUL_RUN : (state == MUL_RUN && last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      bus.done <= 1'b0;
      bus.alu_out <= '0;
      bus.alu_out_hi <= '0;
      bus.carry_out <= 1'b0;
      bus.zero <= 1'b0;
      bus.negative <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      state <= state_d;
      bus.done <= 1'b0;
      if (go_mul) begin
        acc <= '0;
        mcand <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        cnt <= '0;
      end else if (go) begin
        bus.alu_out <= res;
        bus.alu_out_hi <= '0;
        bus.carry_out <= c;
        bus.zero <= res == '0;
        bus.negative <= res[WIDTH-1];
        bus.overflow <= ovf;
        bus.done <= 1'b1;
      end
      if (state == MUL_RUN) begin
        acc <= prod;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          bus.alu_out <= prod[WIDTH-1:0];
          bus.alu_out_hi <= prod[2*WIDTH-1:WIDTH];
          bus.carry_out <= prod[2*WIDTH-1:WIDTH] != '0;
          bus.zero <= prod == '0;
          bus.negative <= prod[2*WIDTH-1];
          bus.overflow <= 1'b0;
          bus.done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_param_seq_alu.sv
// tb_param_seq_alu: directed checks of param_seq_alu at WIDTH=8 and WIDTH=16.
module tb_param_seq_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  param_seq_alu_if #(.WIDTH(8))  b ();
  param_seq_alu_if #(.WIDTH(16)) w ();
  param_seq_alu #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b));
  param_seq_alu #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(w));
  // {done, hi, lo, carry, zero, negative, overflow}
  logic [20:0] o8;
  logic [36:0] o16;
  assign o8 = {b.done, b.alu_out_hi, b.alu_out, b.carry_out, b.zero, b.negative, b.overflow};
  assign o16 = {w.done, w.alu_out_hi, w.alu_out, w.carry_out, w.zero, w.negative, w.overflow};
  logic [2:0]  lf [6] = '{3'd3, 3'd4, 3'd6, 3'd5, 3'd2, 3'd0};
  logic [7:0]  la [6] = '{8'h81, 8'h01, 8'h0F, 8'hF0, 8'hA5, 8'h7F};
  logic [7:0]  lb [6] = '{8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h01};
  logic [20:0] le [6] = '{{1'b1, 8'h00, 8'h02, 4'b1000}, {1'b1, 8'h00, 8'h00, 4'b1100},
                          {1'b1, 8'h00, 8'hF0, 4'b0010}, {1'b1, 8'h00, 8'h30, 4'b0000},
                          {1'b1, 8'h00, 8'hA5, 4'b0010}, {1'b1, 8'h00, 8'h80, 4'b0011}};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op8(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
    b.start = 1'b1;
    b.func = f;
    b.reg1 = x;
    b.reg2 = y;
    tick;
    b.start = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    checks++;
    if ({b.busy, o8} !== 22'd0) begin
      errs++;
      $display("FAIL reset8 got %h exp 0", {b.busy, o8});
    end
    checks++;
    if ({w.busy, o16} !== 38'd0) begin
      errs++;
      $display("FAIL reset16 got %h exp 0", {w.busy, o16});
    end
  endtask
  task automatic test_add;
    op8(3'd0, 8'hFF, 8'h01);
    checks++;
    if (o8 !== {1'b1, 8'h00, 8'h00, 4'b1100}) begin
      errs++;
      $display("FAIL add_ff_01 got %h exp %h", o8, {1'b1, 8'h00, 8'h00, 4'b1100});
    end
    tick;
    checks++;
    if (o8 !== {1'b0, 8'h00, 8'h00, 4'b1100}) begin
      errs++;
      $display("FAIL add_done_drop got %h exp %h", o8, {1'b0, 8'h00, 8'h00, 4'b1100});
    end
  endtask
  task automatic test_sub;
    op8(3'd1, 8'h80, 8'h01);
    checks++;
    if (o8 !== {1'b1, 8'h00, 8'h7F, 4'b1001}) begin
      errs++;
      $display("FAIL sub_80_01 got %h exp %h", o8, {1'b1, 8'h00, 8'h7F, 4'b1001});
    end
    op8(3'd1, 8'h00, 8'h01);
    checks++;
    if (o8 !== {1'b1, 8'h00, 8'hFF, 4'b0010}) begin
      errs++;
      $display("FAIL sub_00_01 got %h exp %h", o8, {1'b1, 8'h00, 8'hFF, 4'b0010});
    end
  endtask
  task automatic test_logic;
    for (int i = 0; i < 6; i++) begin
      op8(lf[i], la[i], lb[i]);
      checks++;
      if (o8 !== le[i]) begin
        errs++;
        $display("FAIL logic_%0d got %h exp %h", i, o8, le[i]);
      end
    end
  endtask
  task automatic test_mul;
    int n;
    op8(3'd7, 8'hFF, 8'hFF);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      checks++;
      if ({b.busy, b.done} !== 2'b10) begin
        errs++;
        $display("FAIL mul_busy_c%0d got %b exp 10", cyc, {b.busy, b.done});
      end
      tick;
    end
    checks++;
    if ({b.busy, o8} !== {1'b0, 1'b1, 8'hFE, 8'h01, 4'b1010}) begin
      errs++;
      $display("FAIL mul_ffxff got %h exp %h", {b.busy, o8}, {1'b0, 1'b1, 8'hFE, 8'h01, 4'b1010});
    end
    op8(3'd0, 8'h10, 8'h20);
    checks++;
    if (o8 !== {1'b1, 8'h00, 8'h30, 4'b0000}) begin
      errs++;
      $display("FAIL add_in_done_cycle got %h exp %h", o8, {1'b1, 8'h00, 8'h30, 4'b0000});
    end
    op8(3'd7, 8'h00, 8'h5A);
    n = 0;
    while (!b.done && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (o8 !== {1'b1, 8'h00, 8'h00, 4'b0100}) begin
      errs++;
      $display("FAIL mul_zero got %h exp %h (waited %0d)", o8, {1'b1, 8'h00, 8'h00, 4'b0100}, n);
    end
  endtask
  task automatic test_busy_ignore;
    int ndone = 0;
    int dcyc = 0;
    op8(3'd7, 8'h12, 8'h34);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (b.done) begin
        ndone++;
        dcyc = cyc;
      end
      b.start = (cyc == 3 || cyc == 5);
      b.func = 3'd0;
      b.reg1 = 8'h01;
      b.reg2 = 8'h01;
      tick;
    end
    b.start = 1'b0;
    checks++;
    if (ndone !== 1 || dcyc !== 9) begin
      errs++;
      $display("FAIL busy_ignore_done got count=%0d cyc=%0d exp count=1 cyc=9", ndone, dcyc);
    end
    checks++;
    if (o8 !== {1'b0, 8'h03, 8'hA8, 4'b1000}) begin
      errs++;
      $display("FAIL busy_ignore_result got %h exp %h", o8, {1'b0, 8'h03, 8'hA8, 4'b1000});
    end
  endtask
  task automatic test_reset_mid;
    int ndone = 0;
    op8(3'd7, 8'hFF, 8'hFF);
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({b.busy, o8} !== 22'd0) begin
      errs++;
      $display("FAIL reset_mid got %h exp 0", {b.busy, o8});
    end
    for (int i = 0; i < 12; i++) begin
      tick;
      if (b.done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errs++;
      $display("FAIL reset_mid_no_done got %0d exp 0", ndone);
    end
    op8(3'd0, 8'h03, 8'h04);
    checks++;
    if (o8 !== {1'b1, 8'h00, 8'h07, 4'b0000}) begin
      errs++;
      $display("FAIL add_after_reset got %h exp %h", o8, {1'b1, 8'h00, 8'h07, 4'b0000});
    end
  endtask
  task automatic test_back_to_back;
    op8(3'd0, 8'h01, 8'h02);
    checks++;
    if (o8 !== {1'b1, 8'h00, 8'h03, 4'b0000}) begin
      errs++;
      $display("FAIL b2b_add got %h exp %h", o8, {1'b1, 8'h00, 8'h03, 4'b0000});
    end
    op8(3'd1, 8'h05, 8'h03);
    checks++;
    if (o8 !== {1'b1, 8'h00, 8'h02, 4'b1000}) begin
      errs++;
      $display("FAIL b2b_sub got %h exp %h", o8, {1'b1, 8'h00, 8'h02, 4'b1000});
    end
    op8(3'd5, 8'hFF, 8'h0F);
    checks++;
    if (o8 !== {1'b1, 8'h00, 8'h0F, 4'b0000}) begin
      errs++;
      $display("FAIL b2b_and got %h exp %h", o8, {1'b1, 8'h00, 8'h0F, 4'b0000});
    end
    tick;
    checks++;
    if (b.done !== 1'b0) begin
      errs++;
      $display("FAIL b2b_done_drop got %b exp 0", b.done);
    end
  endtask
  task automatic test_width16;
    w.start = 1'b1;
    w.func = 3'd0;
    w.reg1 = 16'hFFFF;
    w.reg2 = 16'h0001;
    tick;
    checks++;
    if (o16 !== {1'b1, 16'h0000, 16'h0000, 4'b1100}) begin
      errs++;
      $display("FAIL add16 got %h exp %h", o16, {1'b1, 16'h0000, 16'h0000, 4'b1100});
    end
    w.func = 3'd7;
    w.reg2 = 16'hFFFF;
    tick;
    w.start = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      checks++;
      if ({w.busy, w.done} !== 2'b10) begin
        errs++;
        $display("FAIL mul16_busy_c%0d got %b exp 10", cyc, {w.busy, w.done});
      end
      tick;
    end
    checks++;
    if ({w.busy, o16} !== {1'b0, 1'b1, 16'hFFFE, 16'h0001, 4'b1010}) begin
      errs++;
      $display("FAIL mul16 got %h exp %h", {w.busy, o16}, {1'b0, 1'b1, 16'hFFFE, 16'h0001, 4'b1010});
    end
    tick;
    checks++;
    if (w.done !== 1'b0) begin
      errs++;
      $display("FAIL mul16_done_drop got %b exp 0", w.done);
    end
  endtask
  initial begin
    b.start = 1'b0;
    b.func = 3'd0;
    b.reg1 = '0;
    b.reg2 = '0;
    w.start = 1'b0;
    w.func = 3'd0;
    w.reg1 = '0;
    w.reg2 = '0;
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_mul;
    test_busy_ignore;
    test_reset_mid;
    test_back_to_back;
    test_width16;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
